// File: rtl/clkdiv_pkg.sv
// Shared constants, per-channel config record and index-width helper for clk_div_bank.
package clkdiv_pkg;

  localparam int unsigned CLKDIV_MAX_NCH     = 16;
  // Widest divide value a channel can hold; channel W must not exceed this.
  localparam int unsigned CLKDIV_DIV_W       = 32;
  localparam logic [27:0] CLKDIV_DEFAULT_DIV = 28'd49_999_999;

  typedef struct packed {
    logic [CLKDIV_DIV_W-1:0] div;
    logic                    en;
  } ch_cfg_t;

  function automatic int unsigned chan_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, shadow config, pending flag and terminal-count apply.
// CLKDIV_TICK_EN adds a registered rising-edge pulse output.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned  W           = 28,
  parameter logic [W-1:0] DEFAULT_DIV = W'(CLKDIV_DEFAULT_DIV),
  parameter bit           RESET_EN    = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_div,
  input  logic         load_en,
  input  logic         sync,
  output logic         clk_out,
`ifdef CLKDIV_TICK_EN
  output logic         tick,
`endif
  output logic         pending
);

  ch_cfg_t      act_q, act_d;
  ch_cfg_t      shd_q, shd_d;
  logic         pend_q, pend_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         clk_q, clk_d;
  logic         tc;

  // >= rather than == so a lowered div can never strand the counter.
  assign tc = act_q.en && (CLKDIV_DIV_W'(cnt_q) >= act_q.div);

  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    if (sync) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (pend_q) begin
        act_d  = shd_q;
        pend_d = 1'b0;
      end
    end else if (pend_q && (tc || !act_q.en)) begin
      act_d  = shd_q;
      pend_d = 1'b0;
      cnt_d  = '0;
      clk_d  = act_q.en && shd_q.en && !clk_q;
    end else if (tc) begin
      cnt_d = '0;
      clk_d = !clk_q;
    end else if (act_q.en) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = '0;
      clk_d = 1'b0;
    end
    // Accepts only happen while pend_q is clear, so they never race an apply.
    if (load) begin
      shd_d.div = CLKDIV_DIV_W'(load_div);
      shd_d.en  = load_en;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_q  <= '{div: CLKDIV_DIV_W'(DEFAULT_DIV), en: RESET_EN};
      shd_q  <= '0;
      pend_q <= 1'b0;
      cnt_q  <= '0;
      clk_q  <= 1'b0;
    end else begin
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
    end
  end

`ifdef CLKDIV_TICK_EN
  logic tick_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_q <= 1'b0;
    else        tick_q <= clk_d && !clk_q;
  end

  assign tick = tick_q;
`endif

  assign clk_out = clk_q;
  assign pending = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH programmable 50%-duty clock dividers behind a valid/ready config port.
// CLKDIV_TICK_EN adds the per-channel tick output.
module clk_div_bank
  import clkdiv_pkg::*;
#(
  parameter int unsigned  NCH         = 4,
  parameter int unsigned  W           = 28,
  parameter logic [W-1:0] DEFAULT_DIV = W'(CLKDIV_DEFAULT_DIV),
  parameter bit           RESET_EN    = 1'b1,
  localparam int unsigned CW          = chan_w(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_chan,
  input  logic [W-1:0]   cfg_div,
  input  logic           cfg_en,
  input  logic           sync,
`ifdef CLKDIV_TICK_EN
  output logic [NCH-1:0] tick,
`endif
  output logic [NCH-1:0] clk_out
);

  logic [NCH-1:0] pend;
  logic [NCH-1:0] load;

  // Out-of-range channels match nothing: ready stays high and the write is dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (cfg_chan == CW'(c)) cfg_ready = !pend[c];
    end
  end

  always_comb begin
    load = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      load[c] = cfg_valid && cfg_ready && (cfg_chan == CW'(c));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clkdiv_channel #(
      .W           (W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .RESET_EN    (RESET_EN)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .load     (load[g]),
      .load_div (cfg_div),
      .load_en  (cfg_en),
      .sync     (sync),
      .clk_out  (clk_out[g]),
`ifdef CLKDIV_TICK_EN
      .tick     (tick[g]),
`endif
      .pending  (pend[g])
    );
  end

endmodule
